// File: rtl/lz4_sequence_encoder.sv
// LZ4 sequence encoder: turns (lit_len, match_len, offset, last) commands plus a literal stream
// into LZ4 bytes through one registered output stage; the token appears the cycle after accept, and out_ready stalls the whole pipe.
module lz4_sequence_encoder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seq_valid,
    output logic             seq_ready,
    input  logic [LEN_W-1:0] seq_lit_len,
    input  logic [LEN_W-1:0] seq_match_len,
    input  logic [15:0]      seq_offset,
    input  logic             seq_last,
    input  logic             lit_valid,
    output logic             lit_ready,
    input  logic [7:0]       lit_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE, TOKEN, LIT_EXT, LITERALS, OFF_LO, OFF_HI, MATCH_EXT
    } state_t;

    localparam logic [LEN_W-1:0] L1   = LEN_W'(1);
    localparam logic [LEN_W-1:0] L4   = LEN_W'(4);
    localparam logic [LEN_W-1:0] L15  = LEN_W'(15);
    localparam logic [LEN_W-1:0] L255 = LEN_W'(255);

    state_t           state, state_n;
    logic [LEN_W-1:0] lit_cnt, lit_cnt_n, mlen, mlen_n, ext_rem, ext_rem_n;
    logic [15:0]      offset, offset_n;
    logic             last_q, last_n;
    logic             run;
    logic             out_valid_n, out_last_n, err_n;
    logic [7:0]       out_data_n;
    logic             can_load, accept, bad, load, emit_tok, byte_last;
    logic [7:0]       byte_dat;
    logic [3:0]       tok_hi, tok_lo;
    logic [LEN_W-1:0] c_lit, c_mlen, in_mlen;
    logic             c_last;

    assign can_load  = !out_valid || out_ready;
    assign seq_ready = run && (state == IDLE);
    assign lit_ready = (state == LITERALS) && can_load;
    assign accept    = seq_valid && seq_ready;
    assign in_mlen   = seq_match_len - L4;
    assign bad       = !seq_last && ((seq_match_len < L4) || (seq_offset == 16'd0));

    // Token fields come straight from the command when emitted on the accept cycle.
    assign c_lit  = (state == IDLE) ? seq_lit_len : lit_cnt;
    assign c_mlen = (state == IDLE) ? in_mlen     : mlen;
    assign c_last = (state == IDLE) ? seq_last    : last_q;

    always_comb begin
        state_n   = state;
        lit_cnt_n = lit_cnt;
        mlen_n    = mlen;
        ext_rem_n = ext_rem;
        offset_n  = offset;
        last_n    = last_q;
        err_n     = 1'b0;
        load      = 1'b0;
        emit_tok  = 1'b0;
        byte_dat  = 8'h00;
        byte_last = 1'b0;
        tok_hi    = (c_lit >= L15) ? 4'hF : c_lit[3:0];
        tok_lo    = c_last ? 4'h0 : ((c_mlen >= L15) ? 4'hF : c_mlen[3:0]);

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        err_n = 1'b1;
                    end else begin
                        lit_cnt_n = seq_lit_len;
                        mlen_n    = in_mlen;
                        offset_n  = seq_offset;
                        last_n    = seq_last;
                        if (can_load) emit_tok = 1'b1;
                        else          state_n  = TOKEN;
                    end
                end
            end
            TOKEN: begin
                if (can_load) emit_tok = 1'b1;
            end
            LIT_EXT, MATCH_EXT: begin
                if (can_load) begin
                    load = 1'b1;
                    if (ext_rem >= L255) begin
                        byte_dat  = 8'hFF;
                        ext_rem_n = ext_rem - L255;
                    end else begin
                        byte_dat  = ext_rem[7:0];
                        ext_rem_n = '0;
                        state_n   = (state == LIT_EXT) ? LITERALS : IDLE;
                    end
                end
            end
            LITERALS: begin
                if (lit_valid && lit_ready) begin
                    load      = 1'b1;
                    byte_dat  = lit_data;
                    lit_cnt_n = lit_cnt - L1;
                    if (lit_cnt == L1) begin
                        byte_last = last_q;
                        state_n   = last_q ? IDLE : OFF_LO;
                    end
                end
            end
            OFF_LO: begin
                if (can_load) begin
                    load     = 1'b1;
                    byte_dat = offset[7:0];
                    state_n  = OFF_HI;
                end
            end
            OFF_HI: begin
                if (can_load) begin
                    load     = 1'b1;
                    byte_dat = offset[15:8];
                    if (mlen >= L15) begin
                        ext_rem_n = mlen - L15;
                        state_n   = MATCH_EXT;
                    end else begin
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (emit_tok) begin
            load      = 1'b1;
            byte_dat  = {tok_hi, tok_lo};
            byte_last = c_last && (c_lit == '0);
            if (c_lit >= L15) begin
                ext_rem_n = c_lit - L15;
                state_n   = LIT_EXT;
            end else if (c_lit != '0) begin
                state_n = LITERALS;
            end else begin
                state_n = c_last ? IDLE : OFF_LO;
            end
        end

        out_valid_n = can_load ? load : out_valid;
        out_data_n  = load ? byte_dat : out_data;
        out_last_n  = load ? byte_last : (can_load ? 1'b0 : out_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            lit_cnt   <= '0;
            mlen      <= '0;
            ext_rem   <= '0;
            offset    <= 16'd0;
            last_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            run       <= 1'b1;
            lit_cnt   <= lit_cnt_n;
            mlen      <= mlen_n;
            ext_rem   <= ext_rem_n;
            offset    <= offset_n;
            last_q    <= last_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
            err       <= err_n;
        end
    end

endmodule

// File: doc/lz4_sequence_encoder.md
LZ4_SEQUENCE_ENCODER -- requirements
Module: lz4_sequence_encoder

Interface
REQ-001 Parameter LEN_W, default 16: width of the literal-length and match-length fields.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low.
REQ-004 seq_valid / seq_ready  in/out  1/1  sequence-command handshake.
REQ-005 seq_lit_len  in  LEN_W  number of literal bytes in the sequence.
REQ-006 seq_match_len  in  LEN_W  match length in bytes; must be ≥4 unless seq_last.
REQ-007 seq_offset  in  16  match offset; 1..65535.
REQ-008 seq_last  in  1  final sequence of the block: no offset and no match fields are emitted.
REQ-009 lit_valid / lit_ready  in/out  1/1  literal-byte handshake.
REQ-010 lit_data  in  8  literal byte.
REQ-011 out_valid / out_ready  out/in  1/1  LZ4 byte-stream handshake.
REQ-012 out_data  out  8  encoded byte.
REQ-013 out_last  out  1  marks the final byte of the block.
REQ-014 err  out  1  one-cycle pulse when a command is rejected.

Function
REQ-015 The block shall accept a command only in IDLE, with seq_ready=1 in IDLE and 0 in every other state.
REQ-016 On accept, the block shall latch lit_len, mlen=seq_match_len-4, offset and last.
REQ-017 The token shall be {min(lit_len,15), last ? 0 : min(mlen,15)}.
REQ-018 FSM states: IDLE, TOKEN, LIT_EXT, LITERALS, OFF_LO, OFF_HI, MATCH_EXT.
REQ-019 Transitions, in order: IDLE→TOKEN→LIT_EXT (only if lit_len≥15)→LITERALS (only if lit_len>0)→OFF_LO→OFF_HI→MATCH_EXT (only if mlen≥15)→IDLE.
REQ-020 When last=1, the block shall return to IDLE after the literal phase.
REQ-021 Extension encoding: rem = len-15; emit 0xFF while rem≥255 (rem -= 255), then emit rem (0x00..0xFE).
REQ-022 Extension encoding shall emit at least one byte whenever len≥15, including rem=0.
REQ-023 OFF_LO shall emit offset[7:0]; OFF_HI shall emit offset[15:8].
REQ-024 The output shall be a single registered stage: out_data/out_valid load when !out_valid || out_ready.
REQ-025 out_data shall hold stable while out_valid && !out_ready.
REQ-026 lit_ready shall equal (state==LITERALS) && (!out_valid || out_ready).
REQ-027 Each accepted literal shall be forwarded to out_data on the next cycle, with no added bubbles.
REQ-028 The literal counter shall decrement per accepted literal; LITERALS shall exit when the counter reaches 0.
REQ-029 Throughput shall be one output byte per cycle when out_ready=1; the token shall appear on out_data in the cycle after command accept.
REQ-030 out_last=1 shall be asserted only with the final byte of a last=1 sequence: the final literal, or the token if lit_len=0.
REQ-031 A command with seq_last=0 and seq_match_len<4, or with seq_offset=0, shall be accepted and dropped.
REQ-032 A dropped command shall pulse err for one cycle, emit no bytes, and leave the FSM in IDLE.
REQ-033 Length arithmetic shall be LEN_W bits unsigned with no wrap, since len-15 is computed only when len≥15.

Reset
REQ-034 While rst=0, the block shall force state=IDLE, all counters to 0, out_valid=0, out_data=0x00, out_last=0, err=0, seq_ready=0 and lit_ready=0.
REQ-035 seq_ready shall rise in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-sequence shall discard the partial output, including any held out_data; no resume.

Verification
REQ-037 lit=3, match=4, off=0x0102, last=0, literals AA BB CC → bytes 30 AA BB CC 02 01.
REQ-038 lit=15, match=19, off=0x0010 → FF 00 <15 literals> 10 00 00.
REQ-039 lit=300, last=1 → F0 FF 1E <300 literals>, with out_last on the 300th literal only.
REQ-040 lit=0, last=1 → single byte 00 with out_last=1; seq_ready returns 1 on the next cycle.
REQ-041 Random out_ready stalls over case REQ-037 → identical byte sequence, and out_data stable during every stall.
REQ-042 Error and reset cases:
- match=2, last=0 → err pulse, no out_valid.
- rst low during the literal phase of REQ-038 → out_valid=0 immediately, IDLE after release.
